// File: rtl/cpu.sv
// Minimal 1-bit-instruction CPU: fetch/exec FSM driving board LEDs from switches.
// Optional build macro SWITCH_SYNC_EN adds a 2-flop switch synchronizer.
module cpu #(
    parameter int IO_W = 4
) (
    input  logic            clk,
    input  logic            n_rst,
    input  logic            data,
    output logic            addr,
    input  logic [IO_W-1:0] switch,
    output logic [IO_W-1:0] led
);

    typedef enum logic [1:0] {
        FETCH = 2'b01,
        EXEC  = 2'b10
    } state_t;

    state_t          state;
    logic            pc;
    logic            ir;
    logic [IO_W-1:0] sw_use;

`ifdef SWITCH_SYNC_EN
    logic [IO_W-1:0] sw_s1;
    logic [IO_W-1:0] sw_s2;

    // Two-stage synchronizer for the asynchronous board switches
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= switch;
            sw_s2 <= sw_s1;
        end
    end

    assign sw_use = sw_s2;
`else
    assign sw_use = switch;
`endif

    assign addr = pc;

    // Fetch latches the instruction bit; exec updates led and advances pc
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= FETCH;
            pc    <= 1'b0;
            ir    <= 1'b0;
            led   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    ir    <= (data == 1'b1);
                    state <= EXEC;
                end
                EXEC: begin
                    led   <= ir ? sw_use : '0;
                    pc    <= ~pc;
                    state <= FETCH;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: random stimulus against an instruction-level model.
// Model honours SWITCH_SYNC_EN when the build defines it.
module tb_cpu;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       data;
    logic [3:0] switch;
    logic       addr;
    logic [3:0] led;

    int total = 0;
    int bad   = 0;

    // model state: edges since reset release, last instruction, led, switch history
    int         k;
    logic       ir_m;
    logic [3:0] led_m;
    logic [3:0] d1;
    logic [3:0] d2;

    always #5 clk = ~clk;

    cpu #(.IO_W(4)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .data(data),
        .addr(addr),
        .switch(switch),
        .led(led)
    );

    task automatic model_reset();
        k     = 0;
        ir_m  = 1'b0;
        led_m = 4'h0;
        d1    = 4'h0;
        d2    = 4'h0;
    endtask

    // instruction n = k/2 is fetched from address n mod 2
    function automatic logic exp_addr();
        return ((k / 2) % 2) == 1;
    endfunction

    // advance one clock; odd edges end a fetch, even edges end an execute
    task automatic step();
        logic [3:0] v;
        @(posedge clk);
        k++;
`ifdef SWITCH_SYNC_EN
        v = d2;
`else
        v = switch;
`endif
        if (k % 2 == 1) ir_m = (data === 1'b1);
        else led_m = ir_m ? v : 4'h0;
        d2 = d1;
        d1 = switch;
        #1;
    endtask

    task automatic release_rst();
        n_rst = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        n_rst  = 1'b0;
        data   = 1'b1;
        switch = 4'hF;
        model_reset();
        #1;
        total++;
        if (led !== 4'h0 || addr !== 1'b0) begin
            bad++;
            $display("FAIL reset_now led=%h addr=%b want led=0 addr=0", led, addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (led !== 4'h0 || addr !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold%0d led=%h addr=%b want led=0 addr=0",
                         i, led, addr);
            end
        end
    endtask

    task automatic test_led_on();
        release_rst();
        data   = 1'b1;
        switch = 4'h5;
        for (int i = 0; i < 8; i++) begin
            step();
            total++;
            if (led !== led_m || addr !== exp_addr()) begin
                bad++;
                $display("FAIL led_on%0d led=%h addr=%b want led=%h addr=%b",
                         i, led, addr, led_m, exp_addr());
            end
        end
        total++;
        if (led !== 4'h5) begin
            bad++;
            $display("FAIL led_on_final led=%h want 5", led);
        end
    endtask

    task automatic test_led_off();
        data = 1'b0;
        for (int i = 0; i < 200; i++) begin
            switch = 4'($urandom_range(0, 15));
            step();
            total++;
            if (led !== led_m || addr !== exp_addr()) begin
                bad++;
                $display("FAIL led_off%0d led=%h addr=%b want led=%h addr=%b",
                         i, led, addr, led_m, exp_addr());
            end
        end
        total++;
        if (led !== 4'h0) begin
            bad++;
            $display("FAIL led_off_final led=%h want 0", led);
        end
    endtask

    task automatic test_addr_seq();
        logic [5:0] want;
        n_rst = 1'b0;
        #1;
        release_rst();
        want = 6'b001100;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (addr !== want[5-i]) begin
                bad++;
                $display("FAIL addr_seq%0d addr=%b want %b", i, addr, want[5-i]);
            end
            step();
        end
    endtask

    task automatic test_switch_track();
        logic [3:0] vals [3];
        vals[0] = 4'h5;
        vals[1] = 4'hA;
        vals[2] = 4'h3;
        data = 1'b1;
        for (int v = 0; v < 3; v++) begin
            switch = vals[v];
            for (int i = 0; i < 4; i++) begin
                step();
                total++;
                if (led !== led_m) begin
                    bad++;
                    $display("FAIL track%0d_%0d led=%h want %h", v, i, led, led_m);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            data   = 1'($urandom_range(0, 1));
            switch = 4'($urandom_range(0, 15));
            step();
            total++;
            if (led !== led_m || addr !== exp_addr()) begin
                bad++;
                $display("FAIL rand%0d led=%h addr=%b want led=%h addr=%b",
                         i, led, addr, led_m, exp_addr());
            end
        end
    endtask

    task automatic test_mid_reset();
        int n;
        data   = 1'b1;
        switch = 4'h5;
        n = 0;
        while (!(k % 2 == 1 && led_m == 4'h5) && n < 20) begin
            step();
            n++;
        end
        total++;
        if (led !== 4'h5) begin
            bad++;
            $display("FAIL mid_setup led=%h want 5 (steps=%0d)", led, n);
        end
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if (led !== 4'h0 || addr !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_async led=%h addr=%b want led=0 addr=0", led, addr);
        end
        @(posedge clk);
        #1;
        release_rst();
        total++;
        if (led !== 4'h0 || addr !== 1'b0) begin
            bad++;
            $display("FAIL mid_restart led=%h addr=%b want led=0 addr=0", led, addr);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (led !== led_m || addr !== exp_addr()) begin
                bad++;
                $display("FAIL mid_after%0d led=%h addr=%b want led=%h addr=%b",
                         i, led, addr, led_m, exp_addr());
            end
        end
    endtask

    initial begin
        n_rst  = 1'b0;
        data   = 1'b0;
        switch = 4'h0;
        model_reset();
        test_reset();
        test_led_on();
        test_led_off();
        test_addr_seq();
        test_switch_track();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
